ita_output_writer: RTL and testbench

//  Consumer end of the ITA output stream (valid/ready, N*WI-bit beats of requantized results).

---
 rtl/ita_output_writer_pkg.sv | 30 +++
 rtl/ita_output_writer_if.sv | 24 ++
 rtl/ita_output_writer_fifo.sv | 58 +++++
 rtl/ita_output_writer.sv | 154 +++++++++++++++
 tb/tb_ita_output_writer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ita_output_writer_pkg.sv
// Shared types for the ITA output writer: job configuration, FSM states and buffer entries.
// The optional checksum is enabled by defining ITA_OUTPUT_WRITER_CHECKSUM_EN.
package ita_output_writer_pkg;

   localparam int unsigned N         = 16;
   localparam int unsigned WI        = 8;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned CntWidth  = 16;
   localparam int unsigned BeatWidth = N * WI;
   localparam int unsigned BeatBytes = BeatWidth / 8;

   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [CntWidth-1:0]  cnt_t;
   typedef logic [BeatWidth-1:0] beat_t;

   typedef struct packed {
      addr_t base_addr;
      addr_t row_stride;
      cnt_t  num_rows;
      cnt_t  num_col_beats;
   } writer_cfg_t;

   typedef enum logic [1:0] {Idle, Run, Drain, Done} writer_state_e;

   typedef struct packed {
      addr_t addr;
      beat_t data;
   } wr_entry_t;

endpackage

// File: rtl/ita_output_writer_if.sv
// Stream-in / memory-out bundle of the ITA output writer.
// master = the writer, slave = ITA stream source plus memory interconnect.
interface ita_output_writer_if;
   import ita_output_writer_pkg::*;

   logic  oup_valid;
   logic  oup_ready;
   beat_t oup;
   logic  mem_req;
   logic  mem_gnt;
   addr_t mem_addr;
   beat_t mem_wdata;

   modport master (
      input  oup_valid, oup, mem_gnt,
      output oup_ready, mem_req, mem_addr, mem_wdata
   );

   modport slave (
      output oup_valid, oup, mem_gnt,
      input  oup_ready, mem_req, mem_addr, mem_wdata
   );

endinterface

// File: rtl/ita_output_writer_fifo.sv
// Two-entry registered FIFO of {addr, data}; head is never combinationally fed from the input.
module ita_output_writer_fifo
   import ita_output_writer_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  wr_entry_t data_i,
   input  logic      pop_i,
   output wr_entry_t data_o,
   output logic      empty_o,
   output logic      full_o,
   output logic [1:0] cnt_o
);

   wr_entry_t  mem_q [2];
   wr_entry_t  mem_d [2];
   logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       do_push, do_pop;

   assign empty_o = (cnt_q == 2'd0);
   assign full_o  = (cnt_q == 2'd2);
   assign cnt_o   = cnt_q;
   assign data_o  = mem_q[rd_ptr_q];
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ita_output_writer.sv
// Writes ITA output beats to a 2-D matrix in memory (rows inner, column beats outer).
// Define ITA_OUTPUT_WRITER_CHECKSUM_EN to get a running XOR of written beats on checksum_o.
module ita_output_writer
   import ita_output_writer_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  writer_cfg_t         cfg_i,
   ita_output_writer_if.master wr_bus,
   output logic                busy_o,
   output logic                done_o,
   output beat_t               checksum_o
);

   writer_state_e state_q, state_d;
   addr_t         stride_q, stride_d, addr_q, addr_d, col_base_q, col_base_d;
   cnt_t          rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
   logic          done_q, done_d;
   logic          fifo_full, fifo_empty;
   logic [1:0]    fifo_cnt;
   wr_entry_t     fifo_head, fifo_in;
   logic          oup_ready, accept, pop, start_ok, zero_job, row_last, last_beat;

   assign start_ok  = start_i && (state_q == Idle);
   assign zero_job  = (cfg_i.num_rows == '0) || (cfg_i.num_col_beats == '0);
   assign accept    = wr_bus.oup_valid && oup_ready;
   assign pop       = !fifo_empty && wr_bus.mem_gnt;
   assign row_last  = (row_q == (rows_q - cnt_t'(1)));
   assign last_beat = row_last && (col_q == (cols_q - cnt_t'(1)));
   assign fifo_in   = {addr_q, wr_bus.oup};

   ita_output_writer_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .data_i  (fifo_in),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .cnt_o   (fifo_cnt)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         Idle:    if (start_i) state_d = zero_job ? Done : Run;
         Run:     if (accept && last_beat) state_d = Drain;
         // Leave as soon as the final grant empties the buffer.
         Drain:   if (fifo_empty || (pop && (fifo_cnt == 2'd1))) state_d = Done;
         Done:    state_d = Idle;
         default: state_d = Idle;
      endcase
   end

   always_comb begin
      oup_ready        = (state_q == Run) && !fifo_full;
      busy_o           = (state_q != Idle);
      done_d           = (state_q == Done);
      wr_bus.oup_ready = oup_ready;
      wr_bus.mem_req   = !fifo_empty;
      wr_bus.mem_addr  = fifo_head.addr;
      wr_bus.mem_wdata = fifo_head.data;
   end

   assign done_o = done_q;

   // Addresses advance incrementally: +stride per row, +beat size per column from col_base.
   always_comb begin
      stride_d   = stride_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      row_d      = row_q;
      col_d      = col_q;
      addr_d     = addr_q;
      col_base_d = col_base_q;
      if (start_ok) begin
         stride_d   = cfg_i.row_stride;
         rows_d     = cfg_i.num_rows;
         cols_d     = cfg_i.num_col_beats;
         row_d      = '0;
         col_d      = '0;
         addr_d     = cfg_i.base_addr;
         col_base_d = cfg_i.base_addr;
      end else if (accept) begin
         if (row_last) begin
            row_d      = '0;
            col_d      = col_q + cnt_t'(1);
            col_base_d = col_base_q + addr_t'(BeatBytes);
            addr_d     = col_base_q + addr_t'(BeatBytes);
         end else begin
            row_d  = row_q + cnt_t'(1);
            addr_d = addr_q + stride_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stride_q   <= '0;
         rows_q     <= '0;
         cols_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         addr_q     <= '0;
         col_base_q <= '0;
         done_q     <= 1'b0;
      end else begin
         stride_q   <= stride_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         row_q      <= row_d;
         col_q      <= col_d;
         addr_q     <= addr_d;
         col_base_q <= col_base_d;
         done_q     <= done_d;
      end
   end

`ifdef ITA_OUTPUT_WRITER_CHECKSUM_EN
   beat_t checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (start_ok) begin
         checksum_d = '0;
      end else if (pop) begin
         checksum_d = checksum_q ^ fifo_head.data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum_o = checksum_q;
`else
   assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_ita_output_writer.sv
// Directed bench for ita_output_writer: queue-based model of address order, buffering and
// handshakes checked every cycle, plus literal address/latency/checksum expectations.
module tb_ita_output_writer;
   import ita_output_writer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   writer_cfg_t cfg = '0;
   logic        busy, done;
   beat_t       checksum;

   ita_output_writer_if bus ();

   ita_output_writer dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .cfg_i      (cfg),
      .wr_bus     (bus),
      .busy_o     (busy),
      .done_o     (done),
      .checksum_o (checksum)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Stream source
   beat_t src_mem [64];
   int    src_wr = 0;
   int    src_rd = 0;
   logic  src_en = 1'b0;
   logic  fire_q = 1'b0;

   initial begin
      bus.oup_valid = 1'b0;
      bus.oup       = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!src_en) src_rd = src_wr;
         else if (fire_q) src_rd++;
         bus.oup_valid = src_en && (src_rd < src_wr);
         bus.oup       = src_mem[src_rd & 63];
      end
   end

   // Grant generator: mode 0 always grants, mode 1 holds each request for 3 cycles first
   int gnt_mode = 0;
   int gnt_wait = 0;

   initial begin
      bus.mem_gnt = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (gnt_mode == 0) begin
            bus.mem_gnt = 1'b1;
         end else if (!bus.mem_req) begin
            bus.mem_gnt = 1'b0;
            gnt_wait    = 0;
         end else if (gnt_wait == 3) begin
            bus.mem_gnt = 1'b1;
            gnt_wait    = 0;
         end else begin
            bus.mem_gnt = 1'b0;
            gnt_wait++;
         end
      end
   end

   // Model and monitor
   int          cyc = 0;
   logic [31:0] exp_addr [$];
   beat_t       exp_data [$];
   int          m_k = 0, m_total = 0, m_rows = 0;
   logic [31:0] m_base = '0, m_stride = '0;
   beat_t       m_xor = '0;
   logic        prev_wait = 1'b0, done_prev = 1'b0;
   logic [31:0] prev_addr = '0;
   beat_t       prev_data = '0;
   int          g_cnt = 0, stall_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
   logic [31:0] got_addr [16];
   int          got_cyc [16];
   beat_t       done_cks = '0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            exp_addr.delete();
            exp_data.delete();
            m_k       = 0;
            m_total   = 0;
            m_xor     = '0;
            prev_wait = 1'b0;
            done_prev = 1'b0;
            fire_q    = 1'b0;
            g_cnt     = 0;
         end else begin
            if (prev_wait) begin
               chk("hold_req", bus.mem_req, 1'b1);
               chk("hold_addr", bus.mem_addr, prev_addr);
               chk("hold_data", bus.mem_wdata, prev_data);
            end
            chk("mem_req", bus.mem_req, exp_addr.size() > 0);
            chk("oup_ready", bus.oup_ready, (m_k < m_total) && (exp_addr.size() < 2));
            if (bus.oup_valid && !bus.oup_ready && (m_k < m_total)) stall_cnt++;
            if (bus.mem_req && bus.mem_gnt && exp_addr.size() > 0) begin
               chk("wr_addr", bus.mem_addr, exp_addr[0]);
               chk("wr_data", bus.mem_wdata, exp_data[0]);
               m_xor = m_xor ^ exp_data[0];
               void'(exp_addr.pop_front());
               void'(exp_data.pop_front());
               if (g_cnt < 16) begin
                  got_addr[g_cnt] = bus.mem_addr;
                  got_cyc[g_cnt]  = cyc;
               end
               g_cnt++;
            end
            fire_q = bus.oup_valid && bus.oup_ready;
            if (fire_q) begin
               longint unsigned a;
               int r, c;
               r = (m_rows > 0) ? (m_k % m_rows) : 0;
               c = (m_rows > 0) ? (m_k / m_rows) : 0;
               a = longint'(m_base) + longint'(r) * longint'(m_stride)
                   + longint'(c) * longint'(BeatBytes);
               exp_addr.push_back(a[31:0]);
               exp_data.push_back(bus.oup);
               m_k++;
            end
            prev_wait = bus.mem_req && !bus.mem_gnt;
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_wdata;
`ifndef ITA_OUTPUT_WRITER_CHECKSUM_EN
            chk("checksum_zero", checksum, '0);
`endif
            if (done) begin
               chk("done_single", done_prev, 1'b0);
               chk("done_all_written", g_cnt, m_total);
`ifdef ITA_OUTPUT_WRITER_CHECKSUM_EN
               chk("done_checksum", checksum, m_xor);
`endif
               done_cnt++;
               done_cyc = cyc;
               done_cks = checksum;
            end
            done_prev = done;
            if (start && !busy) begin
               m_base    = cfg.base_addr;
               m_stride  = cfg.row_stride;
               m_rows    = int'(cfg.num_rows);
               m_total   = int'(cfg.num_rows) * int'(cfg.num_col_beats);
               m_k       = 0;
               m_xor     = '0;
               g_cnt     = 0;
               stall_cnt = 0;
               start_cyc = cyc;
            end
         end
      end
   end

   task automatic load(input int n, input logic [7:0] seed, input logic pow2);
      logic [7:0] b;
      src_en = 1'b0;
      @(posedge clk);
      #2;
      for (int i = 0; i < n; i++) begin
         b = pow2 ? 8'(1 << i) : 8'(seed + 8'(i));
         src_mem[(src_wr + i) & 63] = {N{b}};
      end
      src_wr += n;
      src_en = 1'b1;
   endtask

   task automatic run_job(input logic [31:0] base, input logic [31:0] stride,
                          input int rows, input int cols);
      @(posedge clk);
      #2;
      cfg.base_addr     = base;
      cfg.row_stride    = stride;
      cfg.num_rows      = cnt_t'(rows);
      cfg.num_col_beats = cnt_t'(cols);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int max_cyc);
      for (int i = 0; i < max_cyc && done_cnt == d0; i++) @(posedge clk);
      chk("done_seen", done_cnt != d0, 1'b1);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready"}, bus.oup_ready, 1'b0);
      chk({tag, "_req"}, bus.mem_req, 1'b0);
      chk({tag, "_addr"}, bus.mem_addr, '0);
      chk({tag, "_wdata"}, bus.mem_wdata, '0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_checksum"}, checksum, '0);
   endtask

   task automatic check_addrs(input string tag, input logic [31:0] base);
      logic [31:0] offs [6];
      offs = '{32'h0, 32'h40, 32'h80, 32'h10, 32'h50, 32'h90};
      chk({tag, "_count"}, g_cnt, 6);
      for (int i = 0; i < 6; i++) chk({tag, "_addr"}, got_addr[i], base + offs[i]);
   endtask

   initial begin
      int d0;
      beat_t exp_cks;
      repeat (3) @(posedge clk);
      #2;
      check_reset("reset");
      rst_n = 1'b1;

      // 1: full-rate job
      load(6, 8'h11, 1'b0);
      d0 = done_cnt;
      run_job(32'h1000, 32'h40, 3, 2);
      wait_done(d0, 200);
      check_addrs("t1", 32'h1000);
      chk("t1_no_bubbles", got_cyc[5] - got_cyc[0], 5);
      chk("t1_done_latency", done_cyc - got_cyc[5], 2);

      // 2: slow grants, buffer fills and back-pressures
      gnt_mode = 1;
      load(6, 8'h21, 1'b0);
      d0 = done_cnt;
      run_job(32'h1000, 32'h40, 3, 2);
      wait_done(d0, 400);
      check_addrs("t2", 32'h1000);
      chk("t2_backpressure", stall_cnt > 0, 1'b1);
      gnt_mode = 0;

      // 3: empty job
      load(2, 8'h41, 1'b0);
      d0 = done_cnt;
      run_job(32'h1000, 32'h40, 0, 5);
      wait_done(d0, 50);
      chk("t3_done_latency", done_cyc - start_cyc, 2);
      chk("t3_no_writes", g_cnt, 0);
      chk("t3_no_accepts", m_k, 0);

      // 4: restart attempt mid-job is ignored
      load(6, 8'h61, 1'b0);
      d0 = done_cnt;
      run_job(32'h2000, 32'h40, 3, 2);
      run_job(32'h8000, 32'h4, 1, 1);
      wait_done(d0, 200);
      check_addrs("t4", 32'h2000);

      // 5: asynchronous reset mid-job, then a clean job
      gnt_mode = 1;
      load(6, 8'h81, 1'b0);
      run_job(32'h1000, 32'h40, 3, 2);
      for (int i = 0; i < 200 && g_cnt < 2; i++) @(posedge clk);
      chk("t5_two_written", g_cnt >= 2, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset("t5_reset");
      d0 = done_cnt;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      gnt_mode = 0;
      repeat (3) @(posedge clk);
      chk("t5_no_done_after_reset", done_cnt, d0);
      load(6, 8'hA1, 1'b0);
      run_job(32'h1000, 32'h40, 3, 2);
      wait_done(d0, 200);
      check_addrs("t5", 32'h1000);

      // 6: checksum of 0x01/0x02/0x04 replicated beats
      load(3, 8'h00, 1'b1);
      d0 = done_cnt;
      run_job(32'h3000, 32'h10, 3, 1);
      wait_done(d0, 200);
`ifdef ITA_OUTPUT_WRITER_CHECKSUM_EN
      exp_cks = {N{8'h07}};
`else
      exp_cks = '0;
`endif
      chk("t6_checksum", done_cks, exp_cks);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
